neuron_step_scheduler: RTL and testbench
========================================

# neuron_step_scheduler

Time-multiplexes the shared `potential_adder` datapath across `NUM_NEURONS` neurons. It holds each neuron's membrane potential and the input weight accumulated for the current timestep. On each `start` pulse it walks neurons 0..N-1 through the adder, writes back `final_potential`, records `spike` into a spike vector, and then pulses `done`. It sits between the spike-routing/weight logic (which writes weights) and the adder.

## Interface
- `NUM_NEURONS`, default 10: number of neurons sequenced per timestep.
- `ADDR_W`, default 4: neuron index width; must satisfy 2^ADDR_W ≥ NUM_NEURONS.
- `ADDER_LATENCY`, default 2: number of wait cycles between operand issue and result capture; valid range is ≥1.

- `CLK_Scheduler`  in  1  sole clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  begins a timestep; sampled only in IDLE.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse at the end of a timestep.
- `wr_en`  in  1  configuration write strobe.
- `wr_sel`  in  1  write target: 0 = weight table, 1 = potential table.
- `wr_addr`  in  ADDR_W  neuron index for the write.
- `wr_data`  in  32  IEEE-754 single-precision value to write.
- `rd_addr`  in  ADDR_W  readback index.
- `rd_data`  out  32  combinational readback: potential[rd_addr].
- `input_weight`  out  32  operand to the adder: weight[idx].
- `decayed_potential`  out  32  operand to the adder: potential[idx].
- `adder_valid`  out  1  high while operands are being presented.
- `final_potential`  in  32  result from the adder.
- `spike`  in  1  spike flag from the adder.
- `spike_vector`  out  NUM_NEURONS  bit i holds neuron i's spike from the last timestep.

## Operation
- Storage: `potential[NUM_NEURONS]` and `weight[NUM_NEURONS]`, 32 bits each. The block does no arithmetic; values are opaque 32-bit words.
- FSM states: IDLE, ISSUE, WAIT, CAPTURE, DONE.
  - IDLE: if `start`, then idx←0, spike_vector←0, go to ISSUE. Otherwise stay in IDLE.
  - ISSUE: `adder_valid`=1; wait_cnt←ADDER_LATENCY; go to WAIT.
  - WAIT: `adder_valid`=1; decrement wait_cnt; go to CAPTURE when wait_cnt reaches 1 on this cycle. Duration is exactly ADDER_LATENCY cycles.
  - CAPTURE: `adder_valid`=1. On the exiting edge: potential[idx]←final_potential, spike_vector[idx]←spike, weight[idx]←0. If idx==NUM_NEURONS-1, go to DONE; otherwise idx←idx+1 and go to ISSUE.
  - DONE: `done`=1 for this single cycle; go to IDLE.
- Operand outputs are driven from idx in every state. They stay stable from ISSUE through CAPTURE for a given neuron.
- Outputs of unused indices (≥NUM_NEURONS): `rd_data`=0; writes to those indices are ignored.
- Configuration writes:
  - Weight writes are accepted in any state.
  - Potential writes are accepted only in IDLE and are ignored while `busy`.
- Weight writes overwrite; they do not accumulate. The upstream block sums weights.
- A `start` received while `busy` is ignored; it is not queued.
- `spike_vector` holds its value from DONE until the next accepted `start`.

## Timing
- Reset values (asynchronous, immediate): state=IDLE, idx=0, `busy`=0, `done`=0, `adder_valid`=0, `spike_vector`=0, all potential and weight entries =0. Consequently `input_weight`=0, `decayed_potential`=0, and `rd_data`=0.
- Each neuron takes ADDER_LATENCY+2 cycles.
- `start` is sampled at edge k. `done` is high during the cycle after edge k+NUM_NEURONS·(ADDER_LATENCY+2). With the defaults this is edge k+40.
- `busy` rises at edge k and falls at the edge that ends the DONE cycle.
- Simultaneous weight write and CAPTURE clear on the same index: the write wins. The new weight is kept for the next timestep.
- Simultaneous potential write and `start` in IDLE: the write is applied, and the timestep uses the new value.
- Reset asserted mid-timestep: the block goes to IDLE immediately and `done` is not pulsed. Tables are cleared to 0.
- `rd_data` is combinational from the table. It reflects a CAPTURE write-back starting the cycle after the edge.

## Test plan
- Reset: assert `reset` mid-WAIT → `busy`=0, `done` never pulses, `spike_vector`=0, `rd_data`=0 for all indices.
- Basic step: write potential[3]=32'h41A00000 and weight[3]=32'h41200000. Adder model returns sum after 2 cycles, with spike=(sum>32'h42200000) → potential[3]=32'h41F00000, spike_vector=0, `done` at start+40, weight[3]=0.
- Spike: potential[7]=32'h42200000, weight[7]=32'h40A00000. Model performs LIF reset → spike_vector=10'b0010000000; potential[7] is the adder's returned value.
- Start during busy: pulse `start` at cycle 10 of a timestep → exactly one `done` pulse, at cycle 40.
- Write collision: write weight[0]=32'h3F800000 on neuron 0's CAPTURE edge → weight[0]=32'h3F800000 after the step. A potential write during busy is ignored.
- Parameter sweep: ADDER_LATENCY=1 and NUM_NEURONS=4 → `done` at start+12. The adder model checks that operands are stable whenever `adder_valid` is high.

Source files
------------

// File: rtl/neuron_step_scheduler_if.sv
// rtl/neuron_step_scheduler_if.sv - operand/result bus between the scheduler and the shared potential adder
interface neuron_step_scheduler_if;
  logic [31:0] input_weight;
  logic [31:0] decayed_potential;
  logic        adder_valid;
  logic [31:0] final_potential;
  logic        spike;

  modport master (
    output input_weight, decayed_potential, adder_valid,
    input  final_potential, spike
  );

  modport slave (
    input  input_weight, decayed_potential, adder_valid,
    output final_potential, spike
  );
endinterface

// File: rtl/neuron_step_scheduler.sv
// rtl/neuron_step_scheduler.sv - walks every neuron through the shared adder once per timestep
module neuron_step_scheduler #(
  parameter int NUM_NEURONS   = 10,
  parameter int ADDR_W        = 4,
  parameter int ADDER_LATENCY = 2
) (
  input  logic                   CLK_Scheduler,
  input  logic                   reset,
  input  logic                   start,
  output logic                   busy,
  output logic                   done,
  input  logic                   wr_en,
  input  logic                   wr_sel,
  input  logic [ADDR_W-1:0]      wr_addr,
  input  logic [31:0]            wr_data,
  input  logic [ADDR_W-1:0]      rd_addr,
  output logic [31:0]            rd_data,
  output logic [NUM_NEURONS-1:0] spike_vector,
  neuron_step_scheduler_if.master adder
);

  localparam int CNT_W = $clog2(ADDER_LATENCY + 1);
  localparam logic [ADDR_W:0]   N_EXT    = (ADDR_W + 1)'(NUM_NEURONS);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_NEURONS - 1);

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_CAPTURE, S_DONE} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] idx;
  logic [CNT_W-1:0]  wait_cnt;
  logic [31:0]       potential [NUM_NEURONS];
  logic [31:0]       weight    [NUM_NEURONS];
  logic              wr_in_range;
  logic              rd_in_range;

  assign wr_in_range = ({1'b0, wr_addr} < N_EXT);
  assign rd_in_range = ({1'b0, rd_addr} < N_EXT);

  always_ff @(posedge CLK_Scheduler or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt         = state;
    busy              = 1'b1;
    done              = 1'b0;
    adder.adder_valid = 1'b0;
    case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) state_nxt = S_ISSUE;
      end
      S_ISSUE: begin
        adder.adder_valid = 1'b1;
        state_nxt         = S_WAIT;
      end
      S_WAIT: begin
        adder.adder_valid = 1'b1;
        if (wait_cnt == CNT_W'(1)) state_nxt = S_CAPTURE;
      end
      S_CAPTURE: begin
        adder.adder_valid = 1'b1;
        state_nxt         = (idx == LAST_IDX) ? S_DONE : S_ISSUE;
      end
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Index, wait counter and spike vector only move on the FSM's own transitions
  always_ff @(posedge CLK_Scheduler or posedge reset) begin
    if (reset) begin
      idx          <= '0;
      wait_cnt     <= '0;
      spike_vector <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            idx          <= '0;
            spike_vector <= '0;
          end
        end
        S_ISSUE: wait_cnt <= CNT_W'(ADDER_LATENCY);
        S_WAIT:  wait_cnt <= wait_cnt - CNT_W'(1);
        S_CAPTURE: begin
          spike_vector[idx] <= adder.spike;
          if (idx != LAST_IDX) idx <= idx + ADDR_W'(1);
        end
        default: ;
      endcase
    end
  end

  // The external write comes after the capture clear so it wins on a same-index collision
  always_ff @(posedge CLK_Scheduler or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_NEURONS; i++) begin
        potential[i] <= '0;
        weight[i]    <= '0;
      end
    end else begin
      if (state == S_CAPTURE) begin
        potential[idx] <= adder.final_potential;
        weight[idx]    <= '0;
      end
      if (wr_en && wr_in_range) begin
        if (!wr_sel)              weight[wr_addr]    <= wr_data;
        else if (state == S_IDLE) potential[wr_addr] <= wr_data;
      end
    end
  end

  assign adder.input_weight      = weight[idx];
  assign adder.decayed_potential = potential[idx];
  assign rd_data                 = rd_in_range ? potential[rd_addr] : 32'h0;

endmodule

// File: tb/tb_neuron_step_scheduler.sv
// tb/tb_neuron_step_scheduler.sv - directed bench for neuron_step_scheduler, default and small configurations
module tb_neuron_step_scheduler;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Single-precision <-> real helpers, valid for zero and normal values
  function automatic real f2r(input logic [31:0] f);
    logic [63:0] d;
    if (f[30:0] == 31'h0) d = {f[31], 63'h0};
    else d = {f[31], 11'(f[30:23]) + 11'd896, f[22:0], 29'h0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] r2f(input real r);
    logic [63:0] d;
    d = $realtobits(r);
    if (r == 0.0) return 32'h0;
    return {d[63], 8'(d[62:52] - 11'd896), d[51:29]};
  endfunction

  // LIF adder model: sum, spike above 40.0, reset potential to 0 on spike
  function automatic logic [32:0] lif(input logic [31:0] p, input logic [31:0] w);
    real s;
    s = f2r(p) + f2r(w);
    if (s > 40.0) return {1'b1, 32'h0};
    return {1'b0, r2f(s)};
  endfunction

  // Default configuration
  logic        start = 1'b0, wr_en = 1'b0, wr_sel = 1'b0;
  logic [3:0]  wr_addr = '0, rd_addr = '0;
  logic [31:0] wr_data = '0;
  logic        busy, done;
  logic [31:0] rd_data;
  logic [9:0]  spike_vector;
  logic [32:0] m_res;

  neuron_step_scheduler_if bus ();
  always_comb m_res = lif(bus.decayed_potential, bus.input_weight);
  assign bus.final_potential = m_res[31:0];
  assign bus.spike           = m_res[32];

  neuron_step_scheduler dut (
    .CLK_Scheduler(clk), .reset(reset), .start(start), .busy(busy), .done(done),
    .wr_en(wr_en), .wr_sel(wr_sel), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_data(rd_data), .spike_vector(spike_vector), .adder(bus)
  );

  // Small configuration: 4 neurons, latency 1
  logic        s_start = 1'b0, s_wr_en = 1'b0, s_wr_sel = 1'b0;
  logic [1:0]  s_wr_addr = '0, s_rd_addr = '0;
  logic [31:0] s_wr_data = '0;
  logic        s_busy, s_done;
  logic [31:0] s_rd_data;
  logic [3:0]  s_spike_vector;
  logic [32:0] s_res;

  neuron_step_scheduler_if s_bus ();
  always_comb s_res = lif(s_bus.decayed_potential, s_bus.input_weight);
  assign s_bus.final_potential = s_res[31:0];
  assign s_bus.spike           = s_res[32];

  neuron_step_scheduler #(.NUM_NEURONS(4), .ADDR_W(2), .ADDER_LATENCY(1)) s_dut (
    .CLK_Scheduler(clk), .reset(reset), .start(s_start), .busy(s_busy), .done(s_done),
    .wr_en(s_wr_en), .wr_sel(s_wr_sel), .wr_addr(s_wr_addr), .wr_data(s_wr_data),
    .rd_addr(s_rd_addr), .rd_data(s_rd_data), .spike_vector(s_spike_vector), .adder(s_bus)
  );

  int done_cnt = 0;
  always @(negedge clk) if (done) done_cnt++;

  // Operands must hold for ADDER_LATENCY+2 valid cycles per neuron
  int          s_ph = 0;
  logic [31:0] s_lw, s_lp;
  always @(negedge clk) begin
    if (reset || !s_bus.adder_valid) s_ph = 0;
    else begin
      if (s_ph == 0) begin
        s_lw = s_bus.input_weight;
        s_lp = s_bus.decayed_potential;
      end else begin
        check_eq("stable_weight", s_bus.input_weight, s_lw);
        check_eq("stable_potential", s_bus.decayed_potential, s_lp);
      end
      s_ph = (s_ph + 1) % 3;
    end
  end

  task automatic wr(input logic sel, input logic [3:0] a, input logic [31:0] d);
    wr_en = 1'b1; wr_sel = sel; wr_addr = a; wr_data = d;
    @(posedge clk); #1;
    wr_en = 1'b0;
  endtask

  task automatic rd_check(input string tag, input logic [3:0] a, input logic [31:0] exp);
    rd_addr = a; #1;
    check_eq(tag, rd_data, exp);
  endtask

  // mode 1: extra start at cycle 10; mode 2: collision writes at neuron 0 CAPTURE and mid-step
  task automatic run_step(input int mode, output int lat);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; wr_en = 1'b0;
    lat = 0;
    while (!done && lat < 400) begin
      if (mode == 1 && lat == 10) start = 1'b1;
      if (mode == 2 && lat == 3) begin
        wr_en = 1'b1; wr_sel = 1'b0; wr_addr = 4'd0; wr_data = 32'h3F800000;
      end
      if (mode == 2 && lat == 5) begin
        wr_en = 1'b1; wr_sel = 1'b1; wr_addr = 4'd2; wr_data = 32'h12345678;
      end
      @(posedge clk); #1;
      start = 1'b0; wr_en = 1'b0;
      lat++;
    end
  endtask

  int lat;
  int d0;

  initial begin
    repeat (3) @(posedge clk);
    #3 reset = 1'b0;
    @(posedge clk); #1;
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_valid", bus.adder_valid, 0);
    check_eq("rst_spikes", spike_vector, 0);
    check_eq("rst_weight_op", bus.input_weight, 0);
    check_eq("rst_pot_op", bus.decayed_potential, 0);
    rd_check("rst_rd", 4'd3, 32'h0);

    // Basic step: 20.0 + 10.0 = 30.0
    wr(1'b1, 4'd3, 32'h41A00000);
    wr(1'b0, 4'd3, 32'h41200000);
    d0 = done_cnt;
    run_step(0, lat);
    check_eq("basic_lat", lat, 40);
    check_eq("basic_busy_in_done", busy, 1);
    @(posedge clk); #1;
    check_eq("basic_busy_fall", busy, 0);
    check_eq("basic_done_cnt", done_cnt - d0, 1);
    check_eq("basic_spikes", spike_vector, 0);
    rd_check("basic_pot3", 4'd3, 32'h41F00000);

    // Weight 3 was cleared: a second step leaves 30.0 unchanged
    run_step(0, lat);
    @(posedge clk); #1;
    rd_check("weight_cleared", 4'd3, 32'h41F00000);

    // Spike on neuron 7: 40.0 + 5.0 > 40.0
    wr(1'b1, 4'd7, 32'h42200000);
    wr(1'b0, 4'd7, 32'h40A00000);
    run_step(0, lat);
    check_eq("spike_lat", lat, 40);
    repeat (5) @(posedge clk); #1;
    check_eq("spike_vec", spike_vector, 10'b0010000000);
    rd_check("spike_pot7", 4'd7, 32'h0);

    // Start while busy is ignored
    d0 = done_cnt;
    run_step(1, lat);
    check_eq("busy_start_lat", lat, 40);
    repeat (50) @(posedge clk); #1;
    check_eq("busy_start_done_cnt", done_cnt - d0, 1);
    check_eq("busy_start_idle", busy, 0);

    // Weight write on the clearing CAPTURE edge survives; potential write while busy is dropped
    run_step(2, lat);
    @(posedge clk); #1;
    rd_check("collide_pot0", 4'd0, 32'h0);
    rd_check("busy_pot_wr", 4'd2, 32'h0);
    run_step(0, lat);
    @(posedge clk); #1;
    rd_check("collide_weight0", 4'd0, 32'h3F800000);

    // Potential write together with start: 48.0 spikes on neuron 5
    wr_en = 1'b1; wr_sel = 1'b1; wr_addr = 4'd5; wr_data = 32'h42400000;
    run_step(0, lat);
    @(posedge clk); #1;
    check_eq("wr_start_spikes", spike_vector, 10'b0000100000);
    rd_check("wr_start_pot5", 4'd5, 32'h0);

    // Out-of-range indices
    wr(1'b1, 4'd12, 32'hDEADBEEF);
    rd_check("oor_rd12", 4'd12, 32'h0);
    rd_check("oor_rd15", 4'd15, 32'h0);

    // Reset mid-WAIT
    wr(1'b1, 4'd1, 32'h40000000);
    d0 = done_cnt;
    start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    @(posedge clk); @(posedge clk); #2;
    check_eq("pre_rst_valid", bus.adder_valid, 1);
    reset = 1'b1; #1;
    check_eq("mid_rst_busy", busy, 0);
    check_eq("mid_rst_valid", bus.adder_valid, 0);
    check_eq("mid_rst_spikes", spike_vector, 0);
    for (int i = 0; i < 16; i++) rd_check("mid_rst_rd", 4'(i), 32'h0);
    #4 reset = 1'b0;
    repeat (50) @(posedge clk); #1;
    check_eq("mid_rst_no_done", done_cnt - d0, 0);

    // Small configuration: done at start+12
    s_wr_en = 1'b1; s_wr_sel = 1'b1; s_wr_addr = 2'd2; s_wr_data = 32'h41A00000;
    @(posedge clk); #1;
    s_wr_sel = 1'b0; s_wr_data = 32'h41200000;
    @(posedge clk); #1;
    s_wr_sel = 1'b1; s_wr_addr = 2'd1; s_wr_data = 32'h42400000;
    @(posedge clk); #1;
    s_wr_en = 1'b0;
    s_start = 1'b1;
    @(posedge clk); #1; s_start = 1'b0;
    lat = 0;
    while (!s_done && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    check_eq("sweep_lat", lat, 12);
    @(posedge clk); #1;
    check_eq("sweep_busy_fall", s_busy, 0);
    check_eq("sweep_spikes", s_spike_vector, 4'b0010);
    s_rd_addr = 2'd2; #1;
    check_eq("sweep_pot2", s_rd_data, 32'h41F00000);
    s_rd_addr = 2'd1; #1;
    check_eq("sweep_pot1", s_rd_data, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
